// File: rtl/conv_result_writer.sv
// conv_result_writer: write-side address generator for a sliding-window
// convolution. Takes one result per window anchor in raster order and emits
// registered RAM write strobe/address/data at base_addr + row*OUT_W + col,
// then pulses frame_done alongside the final write.
module conv_result_writer #(
  parameter int H_WINDOW_LEN = 5,
  parameter int V_WINDOW_LEN = 5,
  parameter int H_IMAGE_LEN  = 30,
  parameter int V_IMAGE_LEN  = 30,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       col_idx,
  output logic [15:0]       row_idx
);

  localparam int OUT_W = H_IMAGE_LEN - H_WINDOW_LEN + 1;
  localparam int OUT_H = V_IMAGE_LEN - V_WINDOW_LEN + 1;

  localparam logic [15:0] LAST_COL = 16'(OUT_W - 1);
  localparam logic [15:0] LAST_ROW = 16'(OUT_H - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [15:0]       col_q,     col_d;
  logic [15:0]       row_q,     row_d;
  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  // Next-state: frame arming, beat acceptance with raster index stepping, DONE hand-off
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    col_d     = col_q;
    row_d     = row_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = base_addr;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_RUN: begin
        // in_ready is high throughout RUN, so in_valid alone means acceptance
        if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = in_data;
          addr_d    = addr_q + ADDR_W'(1);
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 16'd1;
            if (row_q == LAST_ROW) begin
              state_d = S_DONE;
            end
          end else begin
            col_d = col_q + 16'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      col_q     <= col_d;
      row_q     <= row_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign in_ready   = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN) || (state_q == S_DONE);
  assign frame_done = (state_q == S_DONE);
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign col_idx    = col_q;
  assign row_idx    = row_q;

endmodule

// File: tb/tb_conv_result_writer.sv
// Bench for conv_result_writer: random and directed stimulus compared each
// cycle against a beat-counting reference model (address = base + beats so far).
module tb_conv_result_writer;

  localparam int OUT_W = 26;
  localparam int OUT_H = 26;
  localparam int TOTAL = OUT_W * OUT_H;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        frame_done;
  logic [15:0] col_idx;
  logic [15:0] row_idx;

  conv_result_writer #(
    .H_WINDOW_LEN(5),
    .V_WINDOW_LEN(5),
    .H_IMAGE_LEN (30),
    .V_IMAGE_LEN (30),
    .DATA_W      (32),
    .ADDR_W      (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .frame_done(frame_done),
    .col_idx   (col_idx),
    .row_idx   (row_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: frame is a run of TOTAL beats; the k-th beat goes to base+k.
  bit          m_run;
  bit          m_done;
  int          m_cnt;
  logic [31:0] m_base;
  bit          e_wr_en;
  logic [31:0] e_addr;
  logic [31:0] e_data;

  int obs_writes;
  int obs_dones;

  function automatic logic [99:0] dut_vec();
    return {in_ready, wr_en, busy, frame_done, wr_addr, wr_data, col_idx, row_idx};
  endfunction

  function automatic logic [99:0] exp_vec();
    return {m_run, e_wr_en, (m_run || m_done), m_done, e_addr, e_data,
            16'(m_cnt % OUT_W), 16'(m_cnt / OUT_W)};
  endfunction

  // Apply one cycle of inputs, advance the model, sample 1 ns after the edge
  task automatic drive(input bit r, input bit s, input logic [31:0] b,
                       input bit v, input logic [31:0] d);
    rst = r; start = s; base_addr = b; in_valid = v; in_data = d;
    if (r) begin
      m_run = 0; m_done = 0; m_cnt = 0; m_base = '0;
      e_wr_en = 0; e_addr = '0; e_data = '0;
    end else begin
      e_wr_en = 0;
      if (m_done) begin
        m_done = 0;
        m_cnt  = 0;
      end else if (m_run) begin
        if (v) begin
          e_wr_en = 1;
          e_addr  = m_base + 32'(m_cnt);
          e_data  = d;
          m_cnt++;
          if (m_cnt == TOTAL) begin
            m_run  = 0;
            m_done = 1;
          end
        end
      end else if (s) begin
        m_run  = 1;
        m_base = b;
        m_cnt  = 0;
      end
    end
    @(posedge clk);
    #1;
    if (wr_en === 1'b1) obs_writes++;
    if (frame_done === 1'b1) obs_dones++;
  endtask

  task automatic test_reset();
    drive(1, 1, $urandom, 1, $urandom);
    n_vec++;
    if (dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_first: got %h want %h", dut_vec(), exp_vec());
    end
    drive(1, 0, '0, 0, '0);
    n_vec++;
    if (dut_vec() !== 100'd0) begin
      n_err++;
      $display("FAIL reset_zero: got %h want 0", dut_vec());
    end
  endtask

  task automatic test_nominal();
    obs_writes = 0; obs_dones = 0;
    drive(0, 1, 32'h100, 0, '0);
    n_vec++;
    if (dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL nominal_start: got %h want %h", dut_vec(), exp_vec());
    end
    for (int i = 0; i < TOTAL; i++) begin
      drive(0, 0, '0, 1, 32'(i));
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL nominal_beat %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (wr_addr !== 32'h3A3 || frame_done !== 1'b1 || wr_data !== 32'd675) begin
      n_err++;
      $display("FAIL nominal_last: got addr %h done %b data %0d want 3a3 1 675",
               wr_addr, frame_done, wr_data);
    end
    // extra beats offered after the frame must be back-pressured
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, '0, 1, $urandom);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL nominal_extra %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (obs_writes !== TOTAL || obs_dones !== 1) begin
      n_err++;
      $display("FAIL nominal_counts: got %0d writes %0d dones want %0d 1",
               obs_writes, obs_dones, TOTAL);
    end
  endtask

  task automatic test_row_wrap();
    drive(0, 1, 32'h1000, 0, '0);
    for (int i = 0; i < 27; i++) begin
      drive(0, 0, '0, 1, $urandom);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL row_wrap_beat %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (i == 25) begin
        n_vec++;
        if (wr_addr !== 32'h1019 || col_idx !== 16'd0 || row_idx !== 16'd1) begin
          n_err++;
          $display("FAIL row_wrap_edge: got addr %h col %0d row %0d want 1019 0 1",
                   wr_addr, col_idx, row_idx);
        end
      end
      if (i == 26) begin
        n_vec++;
        if (wr_addr !== 32'h101A || col_idx !== 16'd1 || row_idx !== 16'd1) begin
          n_err++;
          $display("FAIL row_wrap_next: got addr %h col %0d row %0d want 101a 1 1",
                   wr_addr, col_idx, row_idx);
        end
      end
    end
    drive(1, 0, '0, 0, '0);
  endtask

  task automatic test_back_to_back();
    bit restarted;
    obs_writes = 0; obs_dones = 0;
    restarted = 0;
    drive(0, 1, $urandom, 0, '0);
    for (int c = 0; c < 5000 && (m_run || m_done); c++) begin
      bit s;
      s = 0;
      if (m_cnt == 300 && !restarted) begin
        s = 1;
        restarted = 1;
      end
      drive(0, s, s ? 32'h800 : $urandom, bit'($urandom_range(0, 1)), $urandom);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL gaps_cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (obs_writes !== TOTAL || obs_dones !== 1 || m_run || m_done) begin
      n_err++;
      $display("FAIL gaps_counts: got %0d writes %0d dones want %0d 1",
               obs_writes, obs_dones, TOTAL);
    end
    drive(0, 1, 32'h800, 0, '0);
    drive(0, 0, '0, 1, 32'hCAFE);
    n_vec++;
    if (wr_en !== 1'b1 || wr_addr !== 32'h800 || wr_data !== 32'hCAFE) begin
      n_err++;
      $display("FAIL restart_first: got en %b addr %h data %h want 1 800 cafe",
               wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_reset_midframe();
    // continues the frame left running by the previous test
    for (int c = 0; c < 4000 && m_cnt < 400; c++) begin
      drive(0, 0, '0, bit'($urandom_range(0, 1)), $urandom);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL midframe_cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    drive(1, 1, 32'h777, 1, $urandom);
    n_vec++;
    if (dut_vec() !== 100'd0) begin
      n_err++;
      $display("FAIL midframe_reset: got %h want 0", dut_vec());
    end
    drive(0, 0, '0, 1, $urandom);
    n_vec++;
    if (dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL idle_ignores_valid: got %h want %h", dut_vec(), exp_vec());
    end
    obs_writes = 0; obs_dones = 0;
    drive(0, 1, 32'h40, 1, 32'hBAD);
    n_vec++;
    if (wr_en !== 1'b0 || in_ready !== 1'b1 || col_idx !== 16'd0 || row_idx !== 16'd0) begin
      n_err++;
      $display("FAIL start_with_valid: got en %b rdy %b col %0d row %0d want 0 1 0 0",
               wr_en, in_ready, col_idx, row_idx);
    end
    for (int c = 0; c < 5000 && (m_run || m_done); c++) begin
      drive(0, 0, '0, bit'($urandom_range(0, 1)), $urandom);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL fresh_cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (obs_writes !== TOTAL || obs_dones !== 1 || m_run || m_done) begin
      n_err++;
      $display("FAIL fresh_counts: got %0d writes %0d dones want %0d 1",
               obs_writes, obs_dones, TOTAL);
    end
  endtask

  task automatic test_wrap();
    bit saw_ffff;
    bit saw_zero;
    saw_ffff = 0; saw_zero = 0;
    drive(0, 1, 32'hFFFF_FF00, 0, '0);
    for (int i = 0; i < TOTAL + 5; i++) begin
      drive(0, 0, '0, 1, $urandom);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL wrap_cycle %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (wr_en === 1'b1 && wr_addr === 32'hFFFF_FFFF) saw_ffff = 1;
      if (wr_en === 1'b1 && wr_addr === 32'h0) saw_zero = 1;
      if (i == TOTAL - 1) begin
        n_vec++;
        if (wr_addr !== 32'h1A3 || frame_done !== 1'b1) begin
          n_err++;
          $display("FAIL wrap_last: got addr %h done %b want 000001a3 1", wr_addr, frame_done);
        end
      end
    end
    n_vec++;
    if (!saw_ffff || !saw_zero) begin
      n_err++;
      $display("FAIL wrap_through: got ffff=%b zero=%b want 1 1", saw_ffff, saw_zero);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    obs_writes = 0; obs_dones = 0;
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_data = '0;
    m_run = 0; m_done = 0; m_cnt = 0; m_base = '0;
    e_wr_en = 0; e_addr = '0; e_data = '0;
    test_reset();
    test_nominal();
    test_row_wrap();
    test_back_to_back();
    test_reset_midframe();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
